// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between the EX/MEM register and write-back.
// Issues aligned loads/stores on a valid/ready data port. Misaligned accesses are trapped
// without a bus request. Load data is extracted and extended. Upstream is stalled while a
// load response is outstanding. Every write-back field leaves this stage through a flop.
module mem_stage #(
    parameter int ADDR_W    = 32,
    parameter int TO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [31:0]       opr_res_i,
    input  logic [31:0]       rs2_data_i,
    input  logic [4:0]        rd_i,
    input  logic              wb_en_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [2:0]        funct3_i,
    output logic              stall_o,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    output logic [3:0]        dmem_wstrb_o,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [31:0]       wb_opr_res_o,
    output logic [31:0]       wb_dmem_rdata_o,
    output logic [4:0]        wb_rd_o,
    output logic              wb_en_o,
    output logic [1:0]        wb_sel_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } state_t;

    // Counter only has to reach TO_CYCLES-1; keep at least one bit when the timeout is off.
    localparam int               CNT_W    = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);
    localparam logic             TO_EN    = (TO_CYCLES > 0);

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Byte strobes select the lane(s) written inside the word.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_strb = 4'b0001 << a;
            2'b01:   store_strb = a[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so the strobes pick the right one.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Pick the addressed byte/half out of the raw word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = w;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_opr_res_q, wb_opr_res_d;
    logic [31:0]      wb_rdata_q, wb_rdata_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_en_q, wb_en_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;
    logic             mem_op_s, mis_s, req_s, stall_s;

    // Request decode: a bus request is only raised from IDLE for an aligned memory op.
    always_comb begin
        mem_op_s = mem_rd_i | mem_wr_i;
        mis_s    = is_misaligned(funct3_i, opr_res_i[1:0]);
        req_s    = (state_q == S_IDLE) & in_valid_i & mem_op_s & ~mis_s;
    end

    // Data-port drive; fields come straight from the held EX/MEM inputs so they stay stable.
    always_comb begin
        dmem_req_valid_o = req_s;
        dmem_we_o        = req_s & mem_wr_i;
        dmem_addr_o      = {opr_res_i[ADDR_W-1:2], 2'b00};
        dmem_wdata_o     = store_data(funct3_i, rs2_data_i);
        if (req_s && mem_wr_i) begin
            dmem_wstrb_o = store_strb(funct3_i, opr_res_i[1:0]);
        end else begin
            dmem_wstrb_o = 4'b0000;
        end
    end

    // Next-state, timeout counter, stall and retire record for the write-back flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_s      = 1'b0;
        wb_valid_d   = 1'b0;
        wb_en_d      = 1'b0;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        wb_opr_res_d = opr_res_i;
        wb_rdata_d   = 32'h0000_0000;
        wb_rd_d      = rd_i;
        wb_sel_d     = wb_sel_i;
        case (state_q)
            S_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (in_valid_i && !mem_op_s) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = wb_en_i;
                end else if (in_valid_i && mis_s) begin
                    wb_valid_d = 1'b1;
                    misalign_d = 1'b1;
                end else if (req_s && mem_wr_i) begin
                    if (dmem_req_ready_i) begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = wb_en_i;
                    end else begin
                        stall_s = 1'b1;
                    end
                end else if (req_s) begin
                    stall_s = 1'b1;
                    if (dmem_req_ready_i) begin
                        state_d = S_WAIT_RSP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            S_WAIT_RSP: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (dmem_rvalid_i) begin
                    stall_s    = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_en_d    = wb_en_i;
                    wb_rdata_d = load_extend(funct3_i, opr_res_i[1:0], dmem_rdata_i);
                    state_d    = S_IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    stall_s    = 1'b0;
                    wb_valid_d = 1'b1;
                    bus_err_d  = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = {CNT_W{1'b0}};
                end else begin
                    state_d = S_WAIT_RSP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and write-back registers; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_opr_res_q <= 32'h0000_0000;
            wb_rdata_q   <= 32'h0000_0000;
            wb_rd_q      <= 5'd0;
            wb_en_q      <= 1'b0;
            wb_sel_q     <= 2'b00;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_valid_q   <= wb_valid_d;
            wb_opr_res_q <= wb_opr_res_d;
            wb_rdata_q   <= wb_rdata_d;
            wb_rd_q      <= wb_rd_d;
            wb_en_q      <= wb_en_d;
            wb_sel_q     <= wb_sel_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall_o         = stall_s;
    assign wb_valid_o      = wb_valid_q;
    assign wb_opr_res_o    = wb_opr_res_q;
    assign wb_dmem_rdata_o = wb_rdata_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_en_o         = wb_en_q;
    assign wb_sel_o        = wb_sel_q;
    assign misalign_o      = misalign_q;
    assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven bench for mem_stage with a retire scoreboard.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic [31:0] opr_res_i, rs2_data_i;
    logic [4:0]  rd_i;
    logic        wb_en_i;
    logic [1:0]  wb_sel_i;
    logic        mem_rd_i, mem_wr_i;
    logic [2:0]  funct3_i;
    logic        stall_o, dmem_req_valid_o, dmem_req_ready_i, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_en_o, misalign_o, bus_err_o;
    logic [31:0] wb_opr_res_o, wb_dmem_rdata_o;
    logic [4:0]  wb_rd_o;
    logic [1:0]  wb_sel_o;

    mem_stage #(.ADDR_W(32), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .opr_res_i(opr_res_i),
        .rs2_data_i(rs2_data_i), .rd_i(rd_i), .wb_en_i(wb_en_i), .wb_sel_i(wb_sel_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .funct3_i(funct3_i), .stall_o(stall_o),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_opr_res_o(wb_opr_res_o), .wb_dmem_rdata_o(wb_dmem_rdata_o),
        .wb_rd_o(wb_rd_o), .wb_en_o(wb_en_o), .wb_sel_o(wb_sel_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        en;
        logic [1:0]  sel;
        int          rdy_wait;   // cycles with ready low before acceptance
        int          rsp_wait;   // WAIT_RSP cycle index carrying rvalid; -1 = never
        logic [31:0] rdata;
        logic [3:0]  x_strb;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_en;
        logic        x_mis;
        logic        x_berr;
    } vec_t;

    typedef struct {
        logic [31:0] opr;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        en;
        logic [1:0]  sel;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[18];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Retire monitor: every retire must match the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", {31'd0, wb_valid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                n_vec++;
                if (wb_opr_res_o !== e.opr || wb_dmem_rdata_o !== e.rdata || wb_rd_o !== e.rd ||
                    wb_en_o !== e.en || wb_sel_o !== e.sel || misalign_o !== e.mis ||
                    bus_err_o !== e.berr) begin
                    n_err++;
                    $display("FAIL retire: got res=%h rdata=%h rd=%0d en=%b sel=%0d mis=%b berr=%b expected res=%h rdata=%h rd=%0d en=%b sel=%0d mis=%b berr=%b",
                             wb_opr_res_o, wb_dmem_rdata_o, wb_rd_o, wb_en_o, wb_sel_o, misalign_o,
                             bus_err_o, e.opr, e.rdata, e.rd, e.en, e.sel, e.mis, e.berr);
                end
            end
        end
    end

    task automatic idle_inputs();
        in_valid_i = 1'b0; opr_res_i = 32'h0; rs2_data_i = 32'h0; rd_i = 5'd0;
        wb_en_i = 1'b0; wb_sel_i = 2'b00; mem_rd_i = 1'b0; mem_wr_i = 1'b0; funct3_i = 3'b000;
        dmem_req_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic check_reset_state();
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en_o}, 32'd0);
        chk("rst_opr_res", wb_opr_res_o, 32'd0);
        chk("rst_rdata", wb_dmem_rdata_o, 32'd0);
        chk("rst_rd", {27'd0, wb_rd_o}, 32'd0);
        chk("rst_sel", {30'd0, wb_sel_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
    endtask

    // Drive one instruction from just after a rising edge until its retire edge has passed.
    task automatic run_vec(input vec_t v);
        logic req;
        logic rv;
        logic last;
        req = v.valid && (v.ld || v.st) && !v.x_mis;
        in_valid_i = v.valid; opr_res_i = v.addr; rs2_data_i = v.rs2; rd_i = v.rd;
        wb_en_i = v.en; wb_sel_i = v.sel; mem_rd_i = v.ld; mem_wr_i = v.st; funct3_i = v.f3;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = v.rdata;
        if (v.valid) begin
            sb.push_back('{opr: v.addr, rdata: v.x_rdata, rd: v.rd, en: v.x_en, sel: v.sel,
                           mis: v.x_mis, berr: v.x_berr});
        end
        if (!req) begin
            dmem_req_ready_i = 1'b1;
            @(negedge clk);
            chk("no_req", {31'd0, dmem_req_valid_o}, 32'd0);
            chk("no_req_stall", {31'd0, stall_o}, 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k <= v.rdy_wait; k++) begin
                dmem_req_ready_i = (k == v.rdy_wait);
                @(negedge clk);
                chk("req_valid", {31'd0, dmem_req_valid_o}, 32'd1);
                chk("req_addr", dmem_addr_o, {v.addr[31:2], 2'b00});
                chk("req_we", {31'd0, dmem_we_o}, {31'd0, v.st});
                chk("req_stall", {31'd0, stall_o}, {31'd0, !(v.st && dmem_req_ready_i)});
                if (v.st) begin
                    chk("req_wstrb", {28'd0, dmem_wstrb_o}, {28'd0, v.x_strb});
                    chk("req_wdata", dmem_wdata_o, v.x_wdata);
                end else begin
                    chk("req_rd_wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
                end
                @(posedge clk); #1;
            end
            dmem_req_ready_i = 1'b0;
            if (v.ld) begin
                for (int k = 0; k < TO; k++) begin
                    rv = (k == v.rsp_wait);
                    last = (k == TO - 1);
                    dmem_rvalid_i = rv;
                    @(negedge clk);
                    chk("wait_req_valid", {31'd0, dmem_req_valid_o}, 32'd0);
                    chk("wait_stall", {31'd0, stall_o}, {31'd0, !(rv || last)});
                    @(posedge clk); #1;
                    if (rv || last) break;
                end
                dmem_rvalid_i = 1'b0;
            end
        end
    endtask

    // After a timeout, a straggling rvalid in IDLE must not retire anything.
    task automatic late_rvalid_seq();
        idle_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        chk("late_rv_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("late_rv_no_retire", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Reset while a load is outstanding: the access is abandoned and a later rvalid ignored.
    task automatic reset_mid_txn_seq();
        in_valid_i = 1'b1; opr_res_i = 32'h20; rd_i = 5'd3; wb_en_i = 1'b1; wb_sel_i = 2'b01;
        mem_rd_i = 1'b1; mem_wr_i = 1'b0; funct3_i = 3'b010; dmem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b0;
        @(negedge clk);
        chk("mid_wait_stall", {31'd0, stall_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("post_rst_no_retire", {31'd0, wb_valid_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          val ld st f3      addr          rs2           rd  en sel  rw rsp rdata         strb     wdata         xrdata        xen mis berr
        vecs[0]  = '{1, 0, 0, 3'b000, 32'h0000_1234, 32'h0,        5,  1, 0,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        1, 0, 0};
        vecs[1]  = '{1, 1, 0, 3'b000, 32'h0000_0103, 32'h0,        6,  1, 1,  0, 3, 32'h80FF_FFFF, 4'b0000, 32'h0,        32'hFFFF_FF80, 1, 0, 0};
        vecs[2]  = '{1, 0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 0,  2, 0, 32'h0,         4'b1100, 32'hABCD_ABCD, 32'h0,       0, 0, 0};
        vecs[3]  = '{1, 1, 0, 3'b010, 32'h0000_0101, 32'h0,        7,  1, 1,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        0, 1, 0};
        vecs[4]  = '{1, 1, 0, 3'b101, 32'h0000_0302, 32'h0,        8,  1, 1,  0, -1, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1};
        vecs[5]  = '{1, 1, 0, 3'b100, 32'h0000_0101, 32'h0,        9,  1, 1,  0, 0, 32'h1234_8000, 4'b0000, 32'h0,        32'h0000_0080, 1, 0, 0};
        vecs[6]  = '{1, 1, 0, 3'b001, 32'h0000_0002, 32'h0,        10, 1, 1,  1, 1, 32'h8001_7FFF, 4'b0000, 32'h0,        32'hFFFF_8001, 1, 0, 0};
        vecs[7]  = '{1, 1, 0, 3'b010, 32'h0000_0010, 32'h0,        11, 1, 1,  0, 2, 32'hDEAD_BEEF, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1, 0, 0};
        vecs[8]  = '{1, 0, 1, 3'b000, 32'h0000_0401, 32'h1122_335A, 0, 0, 0,  1, 0, 32'h0,         4'b0010, 32'h5A5A_5A5A, 32'h0,       0, 0, 0};
        vecs[9]  = '{1, 0, 1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 0, 0, 0,  0, 0, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0,       0, 0, 0};
        vecs[10] = '{1, 0, 1, 3'b001, 32'h0000_0403, 32'h1234_5678, 0, 0, 2,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        0, 1, 0};
        vecs[11] = '{1, 1, 0, 3'b001, 32'h0000_0000, 32'h0,        12, 1, 1,  0, 0, 32'h1234_7FFF, 4'b0000, 32'h0,        32'h0000_7FFF, 1, 0, 0};
        vecs[12] = '{0, 1, 0, 3'b010, 32'h0000_0040, 32'h0,        13, 1, 1,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        0, 0, 0};
        vecs[13] = '{1, 0, 1, 3'b000, 32'h0000_0403, 32'h0000_00FF, 0, 0, 0,  0, 0, 32'h0,         4'b1000, 32'hFFFF_FFFF, 32'h0,       0, 0, 0};
        vecs[14] = '{1, 1, 0, 3'b000, 32'h0000_0001, 32'h0,        14, 1, 1,  0, 0, 32'h0000_7F00, 4'b0000, 32'h0,        32'h0000_007F, 1, 0, 0};
        vecs[15] = '{1, 0, 1, 3'b010, 32'h0000_0402, 32'h0,        0,  0, 0,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        0, 1, 0};
        vecs[16] = '{1, 0, 0, 3'b000, 32'hFFFF_FFFF, 32'h0,        31, 0, 2,  0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        0, 0, 0};
        vecs[17] = '{1, 1, 0, 3'b101, 32'h0000_0002, 32'h0,        15, 1, 1,  0, 0, 32'hBEEF_0000, 4'b0000, 32'h0,        32'h0000_BEEF, 1, 0, 0};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i]);
            if (i == 4) late_rvalid_seq();
        end

        reset_mid_txn_seq();
        run_vec(vecs[0]);

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
